// File: rtl/lfsr_prng_if.sv
// Output word stream of lfsr_prng: packed word with a valid/ready handshake.
interface lfsr_prng_if #(
    parameter int OUT_BITS = 8
) ();
    logic [OUT_BITS-1:0] out_data;
    logic                out_valid;
    logic                out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/lfsr_prng.sv
// Fibonacci LFSR bit generator packing OUT_BITS bits per word onto a valid/ready stream.
// Optional lock-up recovery (all-zero state forced back to SEED) is enabled by defining LFSR_PRNG_LOCKUP_EN.
module lfsr_prng #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
    parameter logic [WIDTH-1:0] SEED     = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int               OUT_BITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             q,
    output logic [WIDTH-1:0] state,
    lfsr_prng_if.master      stream
);
    localparam int             CW   = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
    localparam int             ACW  = (OUT_BITS > 1) ? OUT_BITS - 1 : 1;
    localparam logic [CW-1:0]  LAST = CW'(OUT_BITS - 1);

    typedef enum logic {FILL, HOLD} fsm_t;

    fsm_t                fsm_reg;
    logic [WIDTH-1:0]    sr_reg;
    logic [CW-1:0]       cnt_reg;
    logic [ACW-1:0]      acc_reg;
    logic [OUT_BITS-1:0] out_data_reg;
    logic                out_valid_reg;

    logic                fb;
    logic [WIDTH-1:0]    sr_step;
    logic [OUT_BITS-1:0] word_shift;
    logic                zero_fix;
    logic [WIDTH-1:0]    load_val;
    logic                handshake;
    logic                do_step;
    logic [CW-1:0]       cnt_base;
    logic                word_done;

    assign fb      = ^(sr_reg & TAPS);
    assign sr_step = {sr_reg[WIDTH-2:0], fb};

    // Accumulator holds the bits captured so far; the word is completed by the current MSB.
    generate
        if (OUT_BITS > 1) begin : g_pack
            assign word_shift = {acc_reg, sr_reg[WIDTH-1]};
        end else begin : g_pack1
            assign word_shift = sr_reg[WIDTH-1];
        end
    endgenerate

`ifdef LFSR_PRNG_LOCKUP_EN
    assign zero_fix = (sr_reg == '0);
    assign load_val = (load_data == '0) ? SEED : load_data;
`else
    assign zero_fix = 1'b0;
    assign load_val = load_data;
`endif

    assign handshake = out_valid_reg & stream.out_ready;
    // In HOLD a step is only allowed in the cycle the held word is accepted; it starts the next word.
    assign do_step   = en & ~zero_fix & ((fsm_reg == FILL) | handshake);
    assign cnt_base  = (fsm_reg == HOLD) ? '0 : cnt_reg;
    assign word_done = do_step & (cnt_base == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_reg        <= SEED;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            fsm_reg       <= FILL;
        end else if (load) begin
            sr_reg        <= load_val;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            fsm_reg       <= FILL;
        end else begin
            if (zero_fix) begin
                sr_reg <= SEED;
            end else if (do_step) begin
                sr_reg <= sr_step;
            end

            if (fsm_reg == HOLD && handshake) begin
                out_valid_reg <= 1'b0;
                fsm_reg       <= FILL;
            end

            if (do_step) begin
                acc_reg <= word_shift[ACW-1:0];
                if (word_done) begin
                    out_data_reg  <= word_shift;
                    out_valid_reg <= 1'b1;
                    cnt_reg       <= '0;
                    fsm_reg       <= HOLD;
                end else begin
                    cnt_reg <= cnt_base + CW'(1);
                end
            end
        end
    end

    assign q                = sr_reg[WIDTH-1];
    assign state            = sr_reg;
    assign stream.out_data  = out_data_reg;
    assign stream.out_valid = out_valid_reg;
endmodule

// File: doc/lfsr_prng.md
# lfsr_prng

Parametrised pseudo-random bit and word generator built on a Fibonacci LFSR. Width, tap polynomial, seed and output word size are configurable. Each step yields one bit, and the block packs OUT_BITS consecutive bits into a word delivered over a valid/ready handshake. Typical uses are test-pattern generation, scrambling and noise sources; the block sits between a control register bank (seed load, enable) and any streaming consumer.

## Interface
- WIDTH, 16, LFSR length in bits (3..64).
- TAPS, 16'hB400, feedback mask; bit i set means sr[i] enters the XOR. The default gives x^16+x^14+x^13+x^11+1.
- SEED, 1, non-zero reset and recovery state, WIDTH bits.
- OUT_BITS, 8, bits per output word (1..WIDTH).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  step enable.
- load  in  1  load-state strobe.
- load_data  in  WIDTH  value written by load.
- q  out  1  serial output, equal to sr[WIDTH-1].
- state  out  WIDTH  current LFSR register.
- out_data  out  OUT_BITS  packed word; valid only while out_valid=1.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts the word.

## Operation
- Step definition:
  - fb = XOR of (sr & TAPS).
  - sr_next = {sr[WIDTH-2:0], fb}.
  - The captured bit is sr[WIDTH-1] before the step.
- Packing: the captured bit shifts into the accumulator LSB, so the first captured bit ends in the MSB.
- A bit counter `cnt` runs 0..OUT_BITS-1.
- States:
  - FILL: when en=1, perform one step, capture the bit and increment cnt. When the step completes bit OUT_BITS-1, latch out_data, set out_valid, clear cnt and go to HOLD.
  - HOLD: the LFSR stalls regardless of en and out_data stays stable. On out_valid & out_ready, clear out_valid. In that same cycle, if en=1, perform a step counted as bit 0 of the next word. Go to FILL.
- Continuous en and out_ready give a sustained throughput of one word per OUT_BITS cycles.
- Load:
  - Load has priority over stepping and handshake.
  - sr <= load_data; cnt <= 0; out_valid <= 0; state -> FILL.
  - Any pending word is discarded, even if out_ready=1 in that cycle.
- Reset:
  - sr <= SEED, cnt <= 0, out_valid <= 0, out_data <= 0, state FILL.
  - q therefore resets to SEED[WIDTH-1].
  - Reset takes priority over load and aborts any partial word or held word.
- en=0 in FILL: the LFSR, cnt and accumulator all hold.
- The all-zero state is a lock-up; see Configuration.

## Timing
- Registered outputs: q, state, out_data, out_valid.
- With rst released at edge 0 and en=1 from then on, the first word has out_valid=1 after edge OUT_BITS.
- Once the handshake completes at an edge, out_valid is low in the following cycle. Its next rise is exactly OUT_BITS enabled steps later.
- A load at edge N makes state=load_data visible after edge N.
- q changes only on a step, load or reset.

## Configuration
- LFSR_PRNG_LOCKUP_EN defined:
  - A load with load_data == 0 writes SEED instead.
  - In addition, if sr is ever observed all-zero, the next edge writes SEED with no step taken.
  - The all-zero state therefore never persists for more than one cycle.
- LFSR_PRNG_LOCKUP_EN undefined: load writes load_data verbatim, and an all-zero state remains zero forever. out_data is then 0 for every subsequent word.

## Test plan
- Seed sequence: reset with defaults, then en=1, out_ready=1.
  - First word out_data=8'h00.
  - Second word 8'h01.
  - State after 15 steps is 16'h8016.
- Period: default configuration, en=1, out_ready=1. State returns to 16'h0001 after exactly 65535 steps and not before.
- Backpressure: out_ready=0 for 20 cycles once out_valid rises.
  - out_data and state are stable throughout.
  - Raising out_ready gives one handshake, and the next word equals the non-stalled reference stream.
- Simultaneous events:
  - load (load_data=16'hACE1) together with out_valid & out_ready drops the word and sets state=16'hACE1.
  - rst together with load gives state=SEED.
- Lock-up: load 16'h0000.
  - With LFSR_PRNG_LOCKUP_EN: state=16'h0001 next cycle, and the stream matches the seed-sequence test.
  - Without it: state stays 0 and every word is 8'h00.
- Enable gaps: random en toggling with out_ready=1 gives a word stream identical to the continuous-en stream.
